// File: rtl/wb_pkg.sv
// Shared widths and the result record for the write-back arbiter.
// Optional stall counter is enabled with the WB_STALL_CNT_EN macro.
`timescale 1ns/1ps
package wb_pkg;
    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int REG_AW  = 5;
    localparam int STALL_W = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_result_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Result offers from ALU and load unit, plus the register-file write port.
`timescale 1ns/1ps
interface wb_arbiter_if;
    import wb_pkg::*;

    logic              i_alu_valid;
    logic [REG_AW-1:0] i_alu_rd;
    logic [XLEN-1:0]   i_alu_data;
    logic              o_alu_ready;
    logic              i_ld_valid;
    logic [REG_AW-1:0] i_ld_rd;
    logic [XLEN-1:0]   i_ld_data;
    logic              o_write;
    logic [REG_AW-1:0] o_write_addr;
    logic [XLEN-1:0]   o_write_data;

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data, i_ld_valid, i_ld_rd, i_ld_data,
        output o_alu_ready, o_write, o_write_addr, o_write_data
    );

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data, i_ld_valid, i_ld_rd, i_ld_data,
        input  o_alu_ready, o_write, o_write_addr, o_write_data
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for outstanding loads; x0 never reads busy.
`timescale 1ns/1ps
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set,
    input  logic [REG_AW-1:0] i_set_rd,
    input  logic              i_clr,
    input  logic [REG_AW-1:0] i_clr_rd,
    input  logic [REG_AW-1:0] i_q0_addr,
    input  logic [REG_AW-1:0] i_q1_addr,
    output logic              o_q0_busy,
    output logic              o_q1_busy
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Set is applied after clear so a same-cycle issue and return leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr) w_busy_nxt[i_clr_rd] = 1'b0;
        if (i_set) w_busy_nxt[i_set_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign o_q0_busy = r_busy[i_q0_addr];
    assign o_q1_busy = r_busy[i_q1_addr];
endmodule

// File: rtl/wb_arbiter.sv
// Fixed-priority write-back arbiter (load return beats ALU) with load scoreboard.
// Define WB_STALL_CNT_EN to add the saturating o_stall_cnt output.
`timescale 1ns/1ps
module wb_arbiter
    import wb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    wb_arbiter_if.slave       wb,
    input  logic              i_ld_issue,
    input  logic [REG_AW-1:0] i_ld_issue_rd,
    input  logic [REG_AW-1:0] i_chk_addr0,
    input  logic [REG_AW-1:0] i_chk_addr1,
    output logic              o_busy0,
    output logic              o_busy1
`ifdef WB_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] o_stall_cnt
`endif
);
    logic       w_alu_ready;
    wb_result_t w_acc;
    wb_result_t r_wr_p1;

    assign w_alu_ready    = !wb.i_ld_valid;
    assign wb.o_alu_ready = w_alu_ready;

    always_comb begin
        w_acc = '0;
        if (wb.i_ld_valid)
            w_acc = '{valid: 1'b1, rd: wb.i_ld_rd, data: wb.i_ld_data};
        else if (wb.i_alu_valid)
            w_acc = '{valid: 1'b1, rd: wb.i_alu_rd, data: wb.i_alu_data};
    end

    // Stage p1: registered write port; results to x0 are consumed silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_p1 <= '0;
        end else begin
            r_wr_p1.valid <= w_acc.valid && (w_acc.rd != '0);
            if (w_acc.valid && (w_acc.rd != '0)) begin
                r_wr_p1.rd   <= w_acc.rd;
                r_wr_p1.data <= w_acc.data;
            end
        end
    end

    assign wb.o_write      = r_wr_p1.valid;
    assign wb.o_write_addr = r_wr_p1.rd;
    assign wb.o_write_data = r_wr_p1.data;

    wb_scoreboard u_sb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_set     (i_ld_issue && (i_ld_issue_rd != '0)),
        .i_set_rd  (i_ld_issue_rd),
        .i_clr     (wb.i_ld_valid),
        .i_clr_rd  (wb.i_ld_rd),
        .i_q0_addr (i_chk_addr0),
        .i_q1_addr (i_chk_addr1),
        .o_q0_busy (o_busy0),
        .o_q1_busy (o_busy1)
    );

`ifdef WB_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst)                               r_stall_cnt <= '0;
        else if (wb.i_alu_valid && !w_alu_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, 64, register data width.
REQ-002 Parameter: NREG, 32, architectural register count; address width 5.
REQ-003 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_alu_valid / i_alu_rd / i_alu_data  input  1/5/XLEN  ALU result offer.
REQ-007 o_alu_ready  output  1  ALU result accepted this cycle when high with i_alu_valid.
REQ-008 i_ld_valid / i_ld_rd / i_ld_data  input  1/5/XLEN  load-return offer; always accepted.
REQ-009 i_ld_issue / i_ld_issue_rd  input  1/5  load dispatched to memory; marks rd pending.
REQ-010 i_chk_addr0 / i_chk_addr1  input  5/5  source registers queried by decode.
REQ-011 o_busy0 / o_busy1  output  1/1  queried register has an outstanding load.
REQ-012 o_write / o_write_addr / o_write_data  output  1/5/XLEN  register-file write port drive.

Function
REQ-013 Arbitration SHALL be fixed priority: load return wins; o_alu_ready = !i_ld_valid (combinational).
REQ-014 An accepted result in cycle N SHALL appear on o_write/o_write_addr/o_write_data in cycle N+1 (registered, latency 1).
REQ-015 o_write SHALL be low in any cycle following a cycle with no accepted result; addr/data hold their last value.
REQ-016 An accepted result with rd = 0 SHALL be consumed but SHALL NOT assert o_write.
REQ-017 The scoreboard SHALL hold one busy bit per register; bit 0 is constant 0.
REQ-018 i_ld_issue with rd != 0 SHALL set busy[rd] from the next cycle.
REQ-019 An accepted load return SHALL clear busy[i_ld_rd] from the next cycle, aligned with o_write high.
REQ-020 Issue and return on the same rd in one cycle SHALL leave busy[rd] = 1 (issue wins).
REQ-021 ALU results SHALL NOT modify busy bits.
REQ-022 o_busy0/1 SHALL be combinational reads of the registered busy vector at i_chk_addr0/1.
REQ-023 Upstream guarantees at most one outstanding load per rd; a return to a non-busy rd SHALL still be written.
REQ-024 An ALU offer held while o_alu_ready is low SHALL keep rd/data stable; the block never drops an offer.

Reset
REQ-025 During i_rst: o_write = 0, o_write_addr = 0, o_write_data = 0, busy vector = 0, stall counter = 0.
REQ-026 Reset mid-operation SHALL discard any result accepted in the same cycle; no write issues the following cycle.
REQ-027 o_alu_ready SHALL follow REQ-013 even during reset; offers accepted during reset are discarded.

Configuration
REQ-028 Macro WB_STALL_CNT_EN defined: add output o_stall_cnt (32 bits) counting cycles with i_alu_valid && !o_alu_ready, saturating at 0xFFFFFFFF.
REQ-029 Macro WB_STALL_CNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package wb_pkg SHALL hold XLEN, NREG, REG_AW = 5 and the result-record typedef (valid, rd, data).
REQ-031 Scoreboard SHALL be a sub-module wb_scoreboard (set port, clear port, two query ports, sync reset).

Verification
REQ-032 ALU only: alu_valid, rd=5, data=0x1234 at N -> o_write=1, addr=5, data=0x1234 at N+1; alu_ready=1.
REQ-033 Collision: alu rd=3 and ld rd=7 both valid at N -> ld written at N+1, alu_ready=0 at N, ALU written at N+2 once ld_valid drops.
REQ-034 Scoreboard: issue rd=9 at N -> o_busy0=1 for chk_addr0=9 from N+1; return rd=9 at M -> busy=0 from M+1, o_write addr 9 at M+1.
REQ-035 Same-cycle issue and return rd=4 with busy[4]=1 -> busy[4] stays 1; write to x4 at N+1.
REQ-036 x0: ALU rd=0 data=0xFF -> o_write=0 next cycle; issue rd=0 -> o_busy=0 for addr 0.
REQ-037 Reset: busy[2]=1 and result accepted at N with i_rst=1 -> o_write=0 and all busy=0 at N+1; with WB_STALL_CNT_EN, 10 stalled cycles -> o_stall_cnt=10.
